// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Covers state encoding, the bubble control word and default parameters.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} hc_state_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic [1:0] aluop;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t BUBBLE_CTRL = '0;

  localparam int DEF_INIT_CYCLES = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT     = 255;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic load_use_hit(
    input logic       ex_memread,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic       id_use_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs2
  );
    return ex_memread && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the sequencing controls returned to it.
interface hazard_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       mem_br_taken;
  logic       dmem_busy;

  logic       pcwrite;
  logic       pc_sel;
  logic       fdwrite;
  logic       fd_flush;
  logic       de_flush;
  logic       em_flush;
  logic       de_hold;
  logic       em_hold;
  logic       mw_bubble;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           mem_br_taken, dmem_busy,
    input  pcwrite, pc_sel, fdwrite, fd_flush, de_flush, em_flush,
           de_hold, em_hold, mw_bubble
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           mem_br_taken, dmem_busy,
    output pcwrite, pc_sel, fdwrite, fd_flush, de_flush, em_flush,
           de_hold, em_hold, mw_bubble
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory waits
// and post-reset scrubbing, plus debug counters and a sticky timeout flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int TW  = $clog2(TIMEOUT + 2);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0]  TO_MAX    = TW'(TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LIMIT  = TW'(TIMEOUT);

  hc_state_t      state;
  logic [ICW-1:0] init_cnt;
  logic [TW-1:0]  to_cnt;

  logic pcwrite, pc_sel, fdwrite, fd_flush, de_flush, em_flush;
  logic de_hold, em_hold, mw_bubble;
  logic load_use, br_fire, stall_inc;

  assign load_use = load_use_hit(bus.ex_memread, bus.ex_rd, bus.id_rs1, bus.id_use_rs1,
                                 bus.id_rs2, bus.id_use_rs2);

  // RUN and MEM_WAIT share one rule set: a wait that ends is judged like RUN.
  always_comb begin
    pcwrite   = 1'b0;
    pc_sel    = 1'b0;
    fdwrite   = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    de_hold   = 1'b0;
    em_hold   = 1'b0;
    mw_bubble = 1'b0;
    br_fire   = 1'b0;
    if (rst || state == INIT) begin
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      em_flush  = 1'b1;
      mw_bubble = 1'b1;
    end else if (bus.mem_br_taken && !bus.dmem_busy) begin
      pcwrite  = 1'b1;
      pc_sel   = 1'b1;
      fdwrite  = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      br_fire  = 1'b1;
    end else if (bus.dmem_busy) begin
      de_hold   = 1'b1;
      em_hold   = 1'b1;
      mw_bubble = 1'b1;
    end else if (load_use) begin
      de_flush = 1'b1;
    end else begin
      pcwrite = 1'b1;
      fdwrite = 1'b1;
    end
  end

  assign bus.pcwrite   = pcwrite;
  assign bus.pc_sel    = pc_sel;
  assign bus.fdwrite   = fdwrite;
  assign bus.fd_flush  = fd_flush;
  assign bus.de_flush  = de_flush;
  assign bus.em_flush  = em_flush;
  assign bus.de_hold   = de_hold;
  assign bus.em_hold   = em_hold;
  assign bus.mw_bubble = mw_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      to_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == INIT_LAST) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt + ICW'(1);
          end
        end
        RUN: begin
          if (bus.dmem_busy) begin
            state  <= MEM_WAIT;
            to_cnt <= TW'(1);
            if (TIMEOUT == 0) mem_timeout <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_busy) begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
            // Next count will exceed the limit once the current one reaches it.
            if (to_cnt >= TO_LIMIT) mem_timeout <= 1'b1;
          end else begin
            state  <= RUN;
            to_cnt <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign stall_inc = (state != INIT) && !pcwrite;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_fire),
    .count (flush_events)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It drives the write, hold and flush controls of the PC register and the four inter-stage pipeline registers. Its jobs are:
- load-use stalls;
- taken-branch flushes resolved in MEM;
- multi-cycle data-memory waits;
- post-reset pipeline scrubbing.

It also keeps saturating stall and flush event counters and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- INIT_CYCLES, 4: cycles of forced flush after reset release (≥1).
- CNT_W, 16: width of the performance counters.
- TIMEOUT, 255: maximum consecutive dmem_busy cycles before mem_timeout is set.

Ports:
- clk  in  1  sole clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
- id_use_rs1, id_use_rs2  in  1 each  decode instruction actually reads rs1/rs2.
- ex_memread  in  1  instruction in EX is a load (memread out of the decode/EX register).
- ex_rd  in  5  destination of the EX instruction.
- mem_br_taken  in  1  branch in MEM resolved taken.
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- pcwrite  out  1  PC register update enable.
- pc_sel  out  1  1 = PC loads the branch target; 0 = sequential.
- fdwrite  out  1  fetch/decode register load enable.
- fd_flush, de_flush, em_flush  out  1 each  load a bubble (all controls 0) into fetch/decode, decode/EX, EX/MEM.
- de_hold, em_hold  out  1 each  decode/EX and EX/MEM keep their current contents.
- mw_bubble  out  1  MEM/WB loads regwrite=0, memtoreg=0.
- stall_cycles  out  CNT_W  count of cycles with pcwrite=0 in RUN or MEM_WAIT.
- flush_events  out  CNT_W  count of taken-branch flushes.
- mem_timeout  out  1  sticky; set once dmem_busy has exceeded TIMEOUT consecutive cycles.

## Operation
States: INIT, RUN, MEM_WAIT.

INIT (entered on rst and held while rst is high):
- Outputs: pcwrite=0, fdwrite=0, fd/de/em_flush=1, mw_bubble=1, holds=0.
- init_cnt counts up from 0 after rst deasserts.
- Go to RUN when init_cnt == INIT_CYCLES−1.

RUN, with priority taken-branch > memory wait > load-use:
- **Branch:** if mem_br_taken && !dmem_busy:
  - pcwrite=1, pc_sel=1, fdwrite=1, fd_flush=de_flush=em_flush=1.
  - flush_events++.
  - Stay in RUN.
- **Memory wait:** else if dmem_busy:
  - pcwrite=0, fdwrite=0, de_hold=em_hold=1, mw_bubble=1.
  - Go to MEM_WAIT.
  - to_cnt=1.
- **Load-use:** else if ex_memread && ex_rd≠0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)):
  - pcwrite=0, fdwrite=0, de_flush=1.
  - Stay in RUN.
  - The hazard clears itself next cycle because EX then holds the bubble.
- **Otherwise:** pcwrite=1, fdwrite=1, all flushes, holds and pc_sel at 0.

MEM_WAIT:
- While dmem_busy, outputs are the same as for the memory-wait case in RUN.
- to_cnt increments and saturates at TIMEOUT+1; mem_timeout is set when to_cnt > TIMEOUT.
- When dmem_busy drops:
  - Return to RUN.
  - That same cycle is evaluated with the RUN rules, so a taken branch or load-use hazard frozen in the pipeline is acted on immediately.

Register and counter rules:
- x0 never causes a load-use stall.
- Counters saturate at all-ones; they never wrap.
- mem_timeout is cleared only by rst.
- stall_cycles does not count INIT cycles.

## Timing
- All outputs are combinational from the registered state and the current inputs (Mealy); zero-cycle latency from hazard inputs to controls.
- Reset values (cycle rst is sampled high and after): state=INIT, init_cnt=0, to_cnt=0, stall_cycles=0, flush_events=0, mem_timeout=0.
- Output values during reset are the INIT outputs.
- First pcwrite=1 occurs INIT_CYCLES cycles after the first clock edge with rst=0.
- rst asserted mid-stall or mid-wait takes effect at the next edge: state goes to INIT and counters clear. The INIT outputs are driven during the rst cycle itself.
- mem_br_taken and dmem_busy both high: the wait wins. The branch is taken in the first cycle dmem_busy is low, because em_hold preserves it.
- Load-use stall costs exactly 1 cycle; a taken branch costs 3 squashed slots and 0 stall cycles.
- Counter update is registered: visible the cycle after the event.

## Structure
- hazard_ctrl_pkg contains:
  - typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} hc_state_t;
  - a bubble-control constant (all control fields zero);
  - default parameter constants.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count saturating), instantiated twice for stall_cycles and flush_events.

## Test plan
- **Reset:** hold rst 3 cycles, release.
  - pcwrite=0 and all flushes=1 for exactly 4 cycles.
  - pcwrite=1 on the 5th cycle.
  - Counters = 0.
- **Load-use:** ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1.
  - One cycle of pcwrite=0, fdwrite=0, de_flush=1.
  - stall_cycles=1.
  - Repeat with ex_rd=0 → no stall.
- **Taken branch:** mem_br_taken=1 one cycle.
  - pc_sel=1, pcwrite=1, fd/de/em_flush=1 that cycle.
  - flush_events=1 next cycle.
- **Memory wait:** dmem_busy high 5 cycles with mem_br_taken=1 throughout.
  - 5 cycles of freeze (em_hold=1, mw_bubble=1).
  - Branch flush fires in cycle 6.
  - stall_cycles=5.
- **Timeout:** dmem_busy high 300 cycles.
  - mem_timeout rises after cycle 256 and stays 1 after busy drops.
  - It clears only on rst.
- **Reset mid-wait and saturation:**
  - rst during MEM_WAIT → INIT next edge, counters 0.
  - With CNT_W=4, 20 stall cycles → stall_cycles=15.
